// File: rtl/rv_pkg.sv
// Shared RV32I decode types: pipeline register layouts, opcode map, ALU op
// and immediate-format selectors.
package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_sel_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } IF_ID_t;

  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        alu_src_imm;
    logic        lui;
    logic        auipc;
    alu_op_e     alu_op;
    logic [2:0]  funct3;
  } ID_EX_t;

endpackage

// File: rtl/id_stage_reg_file.sv
// Two-read / one-write register file; x0 reads as zero and reads see a
// same-cycle write-back (write-first bypass).
module reg_file #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1_i,
  input  logic [AW-1:0]   ra2_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o,
  input  logic            we_i,
  input  logic [AW-1:0]   wa_i,
  input  logic [XLEN-1:0] wd_i
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we_i && (wa_i != '0)) regs_d[wa_i] = wd_i;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else     regs_q <= regs_d;
  end

  assign rd1_o = (ra1_i == '0)                ? '0   :
                 (we_i && (wa_i == ra1_i))    ? wd_i : regs_q[ra1_i];
  assign rd2_o = (ra2_i == '0)                ? '0   :
                 (we_i && (wa_i == ra2_i))    ? wd_i : regs_q[ra2_i];

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register read, immediate/control generation,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  IF_ID_t          if_id_i,
  input  logic            flush_id_i,
  input  logic            stall_id_i,
  input  logic            ex_mem_read_i,
  input  logic [4:0]      ex_rd_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            load_use_stall_o,
  output ID_EX_t          id_ex_o
);

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            rs1_used, rs2_used;
  imm_sel_e        imm_sel;
  logic [31:0]     imm;
  alu_op_e         arith_op;
  ID_EX_t          ctl, decoded, bubble, id_ex_d, id_ex_q;

  assign instr  = if_id_i.instr;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  reg_file #(.XLEN(XLEN), .NREGS(NREGS)) u_reg_file (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (rs1),
    .ra2_i (rs2),
    .rd1_o (rs1_data),
    .rd2_o (rs2_data),
    .we_i  (wb_we_i),
    .wa_i  (wb_rd_i),
    .wd_i  (wb_data_i)
  );

  // instr[30] selects SUB only for register-register ops; SRA/SRAI share it.
  always_comb begin
    case (funct3)
      3'b000:  arith_op = (opcode == OPC_OP && instr[30]) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = instr[30] ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  end

  always_comb begin
    ctl          = '0;
    ctl.valid    = 1'b1;
    ctl.pc       = if_id_i.pc;
    ctl.rs1      = rs1;
    ctl.rs2      = rs2;
    ctl.rd       = rd;
    ctl.funct3   = funct3;
    ctl.rs1_data = rs1_data;
    ctl.rs2_data = rs2_data;
    ctl.alu_op   = ALU_ADD;
    imm_sel      = IMM_NONE;
    rs1_used     = 1'b1;
    rs2_used     = 1'b0;
    case (opcode)
      OPC_LUI: begin
        ctl.reg_write = 1'b1; ctl.alu_src_imm = 1'b1; ctl.lui = 1'b1;
        ctl.alu_op = ALU_PASS_B; imm_sel = IMM_U; rs1_used = 1'b0;
      end
      OPC_AUIPC: begin
        ctl.reg_write = 1'b1; ctl.alu_src_imm = 1'b1; ctl.auipc = 1'b1;
        imm_sel = IMM_U; rs1_used = 1'b0;
      end
      OPC_JAL: begin
        ctl.reg_write = 1'b1; ctl.jal = 1'b1; imm_sel = IMM_J; rs1_used = 1'b0;
      end
      OPC_JALR: begin
        ctl.reg_write = 1'b1; ctl.jalr = 1'b1; ctl.alu_src_imm = 1'b1; imm_sel = IMM_I;
      end
      OPC_BRANCH: begin
        ctl.branch = 1'b1; ctl.alu_op = ALU_SUB; imm_sel = IMM_B; rs2_used = 1'b1;
      end
      OPC_LOAD: begin
        ctl.reg_write = 1'b1; ctl.mem_read = 1'b1; ctl.alu_src_imm = 1'b1; imm_sel = IMM_I;
      end
      OPC_STORE: begin
        ctl.mem_write = 1'b1; ctl.alu_src_imm = 1'b1; imm_sel = IMM_S; rs2_used = 1'b1;
      end
      OPC_OP_IMM: begin
        ctl.reg_write = 1'b1; ctl.alu_src_imm = 1'b1; ctl.alu_op = arith_op; imm_sel = IMM_I;
      end
      OPC_OP: begin
        ctl.reg_write = 1'b1; ctl.alu_op = arith_op; rs2_used = 1'b1;
      end
      OPC_FENCE: ;
      default: ctl.illegal = 1'b1;
    endcase
    if (rd == 5'd0) ctl.reg_write = 1'b0;
  end

  always_comb begin
    case (imm_sel)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  assign load_use_stall_o = if_id_i.valid && !flush_id_i && ex_mem_read_i && (ex_rd_i != 5'd0) &&
                            ((rs1_used && (rs1 == ex_rd_i)) || (rs2_used && (rs2 == ex_rd_i)));

  // A bubble is the reset value: no valid, no side-effecting flags.
  always_comb begin
    bubble      = '0;
    bubble.pc   = RESET_PC;
    decoded     = ctl;
    decoded.imm = imm;
  end

  always_comb begin
    id_ex_d = id_ex_q;
    if (flush_id_i)                               id_ex_d = bubble;
    else if (stall_id_i)                          id_ex_d = id_ex_q;
    else if (load_use_stall_o || !if_id_i.valid)  id_ex_d = bubble;
    else                                          id_ex_d = decoded;
  end

  always_ff @(posedge clk) begin
    if (rst) id_ex_q <= bubble;
    else     id_ex_q <= id_ex_d;
  end

  assign id_ex_o = id_ex_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a per-cycle reference model plus hand-computed
// expectations for the key decode, bypass, hazard and priority cases.
module tb_id_stage;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  IF_ID_t      if_id;
  logic        flush, stall, ex_mr, wb_we;
  logic [4:0]  ex_rd, wb_rd;
  logic [31:0] wb_data;
  logic        lus;
  ID_EX_t      idex;

  always #5 clk = ~clk;

  id_stage dut (
    .clk              (clk),
    .rst              (rst),
    .if_id_i          (if_id),
    .flush_id_i       (flush),
    .stall_id_i       (stall),
    .ex_mem_read_i    (ex_mr),
    .ex_rd_i          (ex_rd),
    .wb_we_i          (wb_we),
    .wb_rd_i          (wb_rd),
    .wb_data_i        (wb_data),
    .load_use_stall_o (lus),
    .id_ex_o          (idex)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_bus(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] rf [32];
  ID_EX_t      exp_s;
  logic        exp_bubble = 1'b0;
  logic        live = 1'b0;

  function automatic logic [31:0] rf_read(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_we && wb_rd == r) return wb_data;
    return rf[r];
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OPC_BRANCH || op == OPC_STORE || op == OPC_OP);
  endfunction

  function automatic ID_EX_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                          input logic [31:0] a, input logic [31:0] b);
    ID_EX_t             e;
    logic [8:0]         f;
    logic [31:0]        im;
    alu_op_e            ao;
    alu_op_e            tbl [8];
    logic [6:0]         op;
    logic [2:0]         f3;
    logic signed [11:0] i12, s12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    op  = ins[6:0];
    f3  = ins[14:12];
    i12 = ins[31:20];
    s12 = {ins[31:25], ins[11:7]};
    b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    ao  = tbl[f3];
    if (op == OPC_OP && f3 == 3'd0 && ins[30]) ao = ALU_SUB;
    if (f3 == 3'd5 && ins[30]) ao = ALU_SRA;
    e = '0; f = '0; im = '0;
    e.valid = 1'b1; e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    e.funct3 = f3; e.rs1_data = a; e.rs2_data = b; e.alu_op = ALU_ADD;
    // flag order: reg_write mem_read mem_write branch jal jalr alu_src_imm lui auipc
    case (op)
      OPC_LUI:    begin f = 9'b100000110; im = ins & 32'hFFFF_F000; e.alu_op = ALU_PASS_B; end
      OPC_AUIPC:  begin f = 9'b100000101; im = ins & 32'hFFFF_F000; end
      OPC_JAL:    begin f = 9'b100010000; im = 32'(j21); end
      OPC_JALR:   begin f = 9'b100001100; im = 32'(i12); end
      OPC_BRANCH: begin f = 9'b000100000; im = 32'(b13); e.alu_op = ALU_SUB; end
      OPC_LOAD:   begin f = 9'b110000100; im = 32'(i12); end
      OPC_STORE:  begin f = 9'b001000100; im = 32'(s12); end
      OPC_OP_IMM: begin f = 9'b100000100; im = 32'(i12); e.alu_op = ao; end
      OPC_OP:     begin f = 9'b100000000; e.alu_op = ao; end
      OPC_FENCE:  ;
      default:    e.illegal = 1'b1;
    endcase
    if (e.rd == 5'd0) f[8] = 1'b0;
    {e.reg_write, e.mem_read, e.mem_write, e.branch, e.jal, e.jalr,
     e.alu_src_imm, e.lui, e.auipc} = f;
    e.imm = im;
    return e;
  endfunction

  // Inputs change just after posedge, so at negedge they are the values the
  // next edge will sample.
  always @(negedge clk) begin
    logic [6:0] op;
    logic       hz;
    op = if_id.instr[6:0];
    hz = if_id.valid && !flush && ex_mr && (ex_rd != 5'd0) &&
         ((uses_rs1(op) && if_id.instr[19:15] == ex_rd) ||
          (uses_rs2(op) && if_id.instr[24:20] == ex_rd));
    if (live) begin
      if (exp_bubble)
        chk("model_bubble",
            {24'd0, idex.valid, idex.illegal, idex.reg_write, idex.mem_read,
             idex.mem_write, idex.branch, idex.jal, idex.jalr}, 32'd0);
      else
        chk_bus("model_id_ex", 256'(idex), 256'(exp_s));
      chk("model_load_use", {31'd0, lus}, {31'd0, hz});
    end
    if (rst) begin
      exp_s = '0; exp_s.pc = 32'h0; exp_bubble = 1'b0; live = 1'b1;
    end else if (flush) begin
      exp_bubble = 1'b1;
    end else if (stall) begin
      // hold
    end else if (hz || !if_id.valid) begin
      exp_bubble = 1'b1;
    end else begin
      exp_s = model_decode(if_id.instr, if_id.pc,
                           rf_read(if_id.instr[19:15]), rf_read(if_id.instr[24:20]));
      exp_bubble = 1'b0;
    end
    if (rst) for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    else if (wb_we && wb_rd != 5'd0) rf[wb_rd] = wb_data;
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] ins, input logic [31:0] pc);
    if_id.instr = ins;
    if_id.pc    = pc;
    if_id.valid = 1'b1;
  endtask

  ID_EX_t snap;

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0; ex_mr = 1'b0; ex_rd = 5'd0;
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    if_id = '0;
    step(); step();
    chk("reset_valid", {31'd0, idex.valid}, 32'd0);
    chk("reset_pc", idex.pc, 32'h0);
    chk("reset_reg_write", {31'd0, idex.reg_write}, 32'd0);
    chk("reset_load_use", {31'd0, lus}, 32'd0);
    rst = 1'b0;

    // addi x1,x0,5 ; its rs2 field is 5 but unused, so no hazard
    put(32'h00500093, 32'h0); ex_mr = 1'b1; ex_rd = 5'd5; #1;
    chk("addi_rs2_unused_no_stall", {31'd0, lus}, 32'd0);
    step();
    chk("addi_valid", {31'd0, idex.valid}, 32'd1);
    chk("addi_imm", idex.imm, 32'd5);
    chk("addi_rd", {27'd0, idex.rd}, 32'd1);
    chk("addi_reg_write", {31'd0, idex.reg_write}, 32'd1);
    chk("addi_alu_src_imm", {31'd0, idex.alu_src_imm}, 32'd1);
    chk("addi_rs1_data", idex.rs1_data, 32'd0);
    ex_mr = 1'b0;

    // write-first bypass: add x3,x2,x2 while WB writes x2
    put(32'h002101B3, 32'h4); wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'hDEAD_BEEF;
    step();
    chk("bypass_rs1", idex.rs1_data, 32'hDEAD_BEEF);
    chk("bypass_rs2", idex.rs2_data, 32'hDEAD_BEEF);
    put(32'h000001B3, 32'h8); wb_rd = 5'd0; wb_data = 32'h1234_5678;
    step();
    chk("x0_write_ignored", idex.rs1_data, 32'd0);
    wb_we = 1'b0;
    put(32'h002101B3, 32'hC);
    step();
    chk("x2_stored", idex.rs2_data, 32'hDEAD_BEEF);

    // load-use: add x6,x5,x1 with a load to x5 in EX
    put(32'h00128333, 32'h10); ex_mr = 1'b1; ex_rd = 5'd5; #1;
    chk("load_use_rs1", {31'd0, lus}, 32'd1);
    step();
    chk("load_use_bubble", {31'd0, idex.valid}, 32'd0);
    ex_mr = 1'b0; #1;
    chk("load_use_clear", {31'd0, lus}, 32'd0);
    step();
    chk("after_stall_valid", {31'd0, idex.valid}, 32'd1);
    chk("after_stall_rd", {27'd0, idex.rd}, 32'd6);
    ex_mr = 1'b1; ex_rd = 5'd0; #1;
    chk("ex_rd_zero_no_stall", {31'd0, lus}, 32'd0);
    ex_rd = 5'd1; #1;
    chk("load_use_rs2", {31'd0, lus}, 32'd1);
    ex_mr = 1'b0; ex_rd = 5'd0;

    // immediates
    put(32'hFE000CE3, 32'h20); step();
    chk("beq_imm", idex.imm, 32'hFFFF_FFF8);
    chk("beq_branch", {31'd0, idex.branch}, 32'd1);
    put(32'hFE002E23, 32'h24); step();
    chk("sw_imm", idex.imm, 32'hFFFF_FFFC);
    chk("sw_mem_write", {31'd0, idex.mem_write}, 32'd1);
    put(32'h001000EF, 32'h28); step();
    chk("jal_imm", idex.imm, 32'h0000_0800);
    chk("jal_flag", {31'd0, idex.jal}, 32'd1);
    put(32'h123452B7, 32'h2C); step();
    chk("lui_imm", idex.imm, 32'h1234_5000);

    // flush + stall together -> bubble
    put(32'h00500093, 32'h30); flush = 1'b1; stall = 1'b1; step();
    chk("flush_beats_stall", {31'd0, idex.valid}, 32'd0);
    flush = 1'b0; stall = 1'b0; step();
    chk("reload_valid", {31'd0, idex.valid}, 32'd1);
    snap = idex;
    // stall holds ID/EX while WB still writes x7
    stall = 1'b1; put(32'h002101B3, 32'h34);
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h0000_CAFE;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_bus("stall_hold", 256'(idex), 256'(snap));
      wb_we = 1'b0;
    end
    stall = 1'b0;
    put(32'h00038433, 32'h38); step();
    chk("wb_during_stall", idex.rs1_data, 32'h0000_CAFE);

    // flush masks the hazard request
    put(32'h00128333, 32'h3C); flush = 1'b1; ex_mr = 1'b1; ex_rd = 5'd5; #1;
    chk("flush_masks_load_use", {31'd0, lus}, 32'd0);
    step();
    chk("flush_bubble", {31'd0, idex.valid}, 32'd0);
    flush = 1'b0; ex_mr = 1'b0; ex_rd = 5'd0;

    // invalid input -> bubble
    put(32'h00500093, 32'h40); if_id.valid = 1'b0; step();
    chk("invalid_bubble", {31'd0, idex.valid}, 32'd0);

    // illegal opcode
    put(32'hFFFF_FFFF, 32'h44); step();
    chk("illegal_flag", {31'd0, idex.illegal}, 32'd1);
    chk("illegal_valid", {31'd0, idex.valid}, 32'd1);
    chk("illegal_flags_off", {29'd0, idex.reg_write, idex.mem_write, idex.branch}, 32'd0);

    // mid-stream reset clears ID/EX and the register file
    put(32'h00500093, 32'h48); rst = 1'b1; step();
    chk("midrst_valid", {31'd0, idex.valid}, 32'd0);
    chk("midrst_imm", idex.imm, 32'd0);
    chk("midrst_pc", idex.pc, 32'h0);
    rst = 1'b0;
    put(32'h002101B3, 32'h4C); step();
    chk("midrst_rf_cleared", idex.rs1_data, 32'd0);

    if_id.valid = 1'b0;
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
